// File: rtl/ksa_serial_add32_if.sv
// Handshake and data bundle for the byte-serial 32-bit adder.
// The slave modport is the adder, the master modport is whoever feeds and drains it.
interface ksa_serial_add32_if #(
    parameter int N_BYTES = 4
) ();
    localparam int W = 8 * N_BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/ksa_serial_add32.sv
// Byte-serial adder: captures two W-bit operands and a carry-in, then adds one
// 8-bit slice per clock, LSB first, rippling the carry through a register.
// The result (sum, carry-out, signed overflow) is held until the consumer takes it.
module ksa_serial_add32 #(
    parameter int N_BYTES = 4
) (
    input  logic clk,
    input  logic rst_n,
    ksa_serial_add32_if.slave bus
);
    localparam int W     = 8 * N_BYTES;
    localparam int IDX_W = $clog2(N_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       a_slice [N_BYTES];
    logic [7:0]       b_slice [N_BYTES];
    logic [W-1:0]     sum_written;
    logic [8:0]       slice_res;
    logic             last_slice;

    // Split the operands into byte slices and build the result word with the
    // current slice replaced by this cycle's partial sum.
    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_slice
            assign a_slice[gi] = a_q[8*gi +: 8];
            assign b_slice[gi] = b_q[8*gi +: 8];
            assign sum_written[8*gi +: 8] = (idx_q == IDX_W'(gi)) ? slice_res[7:0]
                                                                   : sum_q[8*gi +: 8];
        end
    endgenerate

    // One 8-bit add per cycle; bit 8 is the carry into the next slice.
    assign slice_res  = {1'b0, a_slice[idx_q]} + {1'b0, b_slice[idx_q]} + {8'd0, carry_q};
    assign last_slice = (idx_q == IDX_W'(N_BYTES - 1));

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sum_written;
                carry_d = slice_res[8];
                if (last_slice) begin
                    // Index is left at the top slice rather than wrapping.
                    cout_d  = slice_res[8];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_res[7] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low clear of all state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_ksa_serial_add32.sv
// Bench for the byte-serial adder: directed vectors with literal expectations,
// plus a transaction-level model checked against the DUT every cycle.
module tb_ksa_serial_add32;
    localparam int N_BYTES = 4;
    localparam int W       = 8 * N_BYTES;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    bit   chk_en;

    ksa_serial_add32_if #(.N_BYTES(N_BYTES)) bus ();

    ksa_serial_add32 #(.N_BYTES(N_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase 0: waiting for operands, 1: computing (cycles_left edges to go), 2: result offered
    int           m_phase;
    int           m_left;
    logic [W-1:0] m_sum, m_pend_sum;
    logic         m_cout, m_ovf, m_pend_cout, m_pend_ovf;

    always @(posedge clk) begin
        logic [W:0] full;
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    full = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{W{1'b0}}, bus.in_cin};
                    m_pend_sum  <= full[W-1:0];
                    m_pend_cout <= full[W];
                    m_pend_ovf  <= (bus.in_a[W-1] == bus.in_b[W-1]) && (full[W-1] != bus.in_a[W-1]);
                    m_left  <= N_BYTES;
                    m_phase <= 1;
                end
                1: begin
                    if (m_left == 1) begin
                        m_sum   <= m_pend_sum;
                        m_cout  <= m_pend_cout;
                        m_ovf   <= m_pend_ovf;
                        m_phase <= 2;
                    end
                    m_left <= m_left - 1;
                end
                default: if (bus.out_ready) m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison; result fields are not observable mid-computation.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("m_in_ready",  bus.in_ready,  (m_phase == 0));
            chk("m_out_valid", bus.out_valid, (m_phase == 2));
            chk("m_busy",      bus.busy,      (m_phase != 0));
            if (m_phase != 1) begin
                chk("m_sum",  bus.out_sum,  m_sum);
                chk("m_cout", bus.out_cout, m_cout);
                chk("m_ovf",  bus.out_ovf,  m_ovf);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                          input int hold, input bit scramble);
        int cyc;
        logic [W-1:0] held_sum;
        @(negedge clk);
        chk("pre_in_ready", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = scramble;
        if (scramble) begin
            bus.in_a   = $urandom;
            bus.in_b   = $urandom;
            bus.in_cin = ~cin;
        end
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid) cyc++;
        end
        chk("latency", cyc, N_BYTES);
        chk("sum",  bus.out_sum,  e_sum);
        chk("cout", bus.out_cout, e_cout);
        chk("ovf",  bus.out_ovf,  e_ovf);
        $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 a, b, cin, bus.out_sum, bus.out_cout, bus.out_ovf, cyc);
        if (hold > 0) begin
            held_sum = bus.out_sum;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bus.in_valid = i[0];
                bus.in_a     = $urandom;
                @(posedge clk);
                #1;
                chk("bp_valid", bus.out_valid, 1'b1);
                chk("bp_ready", bus.in_ready,  1'b0);
                chk("bp_sum",   bus.out_sum,   held_sum);
            end
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("release_valid", bus.out_valid, 1'b0);
            chk("release_ready", bus.in_ready,  1'b1);
        end else begin
            @(posedge clk);
            #1;
            chk("drain_ready", bus.in_ready, 1'b1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_sum",       bus.out_sum,   32'h0);
        rst_n = 1'b1;

        run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 0, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0, 1'b0);
        run_op(32'h00FF00FF, 32'h00010001, 1'b1, 32'h01000101, 1'b0, 1'b0, 5, 1'b0);
        run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDFD10456, 1'b0, 1'b0, 0, 1'b1);

        // Abort an operation two cycles into RUN.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hAAAAAAAA;
        bus.in_b     = 32'h55555555;
        bus.in_cin   = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready",  bus.in_ready,  1'b1);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_sum",       bus.out_sum,   32'h0);
        $display("abort after 2 RUN cycles -> in_ready=%0d out_valid=%0d sum=%h",
                 bus.in_ready, bus.out_valid, bus.out_sum);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", bus.out_valid, 1'b0);
        end
        run_op(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
